// File: rtl/wb_dec_n.sv
//==============================================================================
// Module   : wb_dec_n
// Brief    : Wishbone address decoder / slave mux with boot-slave forcing and
//            bus-error termination. Optional watchdog: WB_DEC_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_dec_n #(
   parameter int AW            = 30,
   parameter int DW            = 32,
   parameter int NS            = 4,
   parameter int SELW          = 4,
   parameter int BOOT_SLAVE    = 1,
   parameter int BOOT_ACCESSES = 2,
   parameter int TIMEOUT       = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stb_i,
   input  logic [AW-1:0]    adr_i,
   output logic             ack_o,
   output logic             err_o,
   output logic [DW-1:0]    dat_o,
   output logic [NS-1:0]    s_stb_o,
   input  logic [NS-1:0]    s_ack_i,
   input  logic [NS*DW-1:0] s_dat_i
);

   localparam int BW = (BOOT_ACCESSES < 1) ? 1 : $clog2(BOOT_ACCESSES + 1);
   localparam logic [BW-1:0]   c_boot_max = BW'(BOOT_ACCESSES);
   localparam logic [SELW:0]   c_ns       = (SELW + 1)'(NS);
   localparam logic [SELW-1:0] c_boot_sel = SELW'(BOOT_SLAVE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [SELW-1:0] r_sel, w_sel_nxt;
   logic [BW-1:0]   r_boot_cnt, w_boot_cnt_nxt;
   logic [SELW-1:0] w_target;
   logic            w_boot_active;
   logic            w_sel_ack;
   logic [DW-1:0]   w_sel_dat;
   logic            w_ack;
   logic            w_err;
   logic            w_busy;
   logic            w_unused;

`ifdef WB_DEC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] c_tmo_lim = TW'(TIMEOUT - 1);
   logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
`endif

   // Only the top SELW address bits take part in decoding.
   assign w_unused      = ^{1'b0, adr_i[AW-SELW-1:0]};
   assign w_boot_active = (r_boot_cnt < c_boot_max);
   assign w_target      = w_boot_active ? c_boot_sel : adr_i[AW-1:AW-SELW];
   assign w_busy        = (r_state == ST_BUSY);

   always_comb begin
      w_sel_ack = 1'b0;
      w_sel_dat = '0;
      for (int i = 0; i < NS; i++) begin
         if (r_sel == SELW'(i)) begin
            w_sel_ack = s_ack_i[i];
            w_sel_dat = s_dat_i[i*DW +: DW];
         end
      end
   end

   for (genvar gi = 0; gi < NS; gi++) begin : g_stb
      assign s_stb_o[gi] = w_busy & stb_i & (r_sel == SELW'(gi));
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_sel_nxt      = r_sel;
      w_boot_cnt_nxt = r_boot_cnt;
      w_ack          = 1'b0;
      w_err          = 1'b0;
`ifdef WB_DEC_TIMEOUT_EN
      w_tmo_cnt_nxt  = r_tmo_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (stb_i) begin
               if ({1'b0, w_target} < c_ns) begin
                  w_sel_nxt   = w_target;
                  w_state_nxt = ST_BUSY;
`ifdef WB_DEC_TIMEOUT_EN
                  w_tmo_cnt_nxt = '0;
`endif
               end else begin
                  w_state_nxt = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            w_ack = w_sel_ack & stb_i;
            if (w_ack) begin
               w_state_nxt = ST_IDLE;
               if (w_boot_active) begin
                  w_boot_cnt_nxt = r_boot_cnt + 1'b1;
               end
            end else if (!stb_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
`ifdef WB_DEC_TIMEOUT_EN
               // Counter stops at the limit, so it can never wrap.
               if (r_tmo_cnt >= c_tmo_lim) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
               end
`endif
            end
         end
         ST_ERR: begin
            w_err       = stb_i;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign ack_o = w_ack;
   assign err_o = w_err;
   assign dat_o = w_ack ? w_sel_dat : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_boot_cnt <= '0;
`ifdef WB_DEC_TIMEOUT_EN
         r_tmo_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_boot_cnt <= w_boot_cnt_nxt;
`ifdef WB_DEC_TIMEOUT_EN
         r_tmo_cnt  <= w_tmo_cnt_nxt;
`endif
      end
   end

endmodule

`default_nettype wire
